// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: CTRL/RX/TX word registers, TX serialiser, and an RX
// deserialiser with a one-byte holding register plus a sticky overrun flag.
module uart_mmio #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int unsigned BIT_CYCLES = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int          CW         = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2);

    if (BIT_CYCLES < 4) begin : g_bit_cycles_chk
        $error("uart_mmio: BIT_CYCLES must be >= 4");
    end

    typedef enum logic [1:0] {ADDR_CTRL, ADDR_RX, ADDR_TX, ADDR_NONE} uart_addr_t;
    typedef struct packed {
        logic overrun;
        logic rx_valid;
        logic tx_ready;
    } uart_ctrl_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- request decode ----------------
    uart_addr_t addr_sel;
    logic       rd, rd_ctrl, rd_rx, tx_wr, tx_ready;
    logic       unused_bits;

    assign req_ready   = 1'b1;
    assign addr_sel    = uart_addr_t'(req_addr[3:2]);
    assign rd          = req_valid && !req_we;
    assign rd_ctrl     = rd && (addr_sel == ADDR_CTRL);
    assign rd_rx       = rd && (addr_sel == ADDR_RX);
    assign tx_wr       = req_valid && req_we && (addr_sel == ADDR_TX) && tx_ready;
    assign unused_bits = ^{req_addr[1:0], req_wdata[31:8]};

    // ---------------- TX ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic [2:0]    tx_bit, tx_bit_n;

    assign tx_ready = (tx_state == TX_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_sh    <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_sh    <= tx_sh_n;
            tx_bit   <= tx_bit_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_sh_n    = tx_sh;
        tx_bit_n   = tx_bit;
        uart_tx    = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                if (tx_wr) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = CNT_BIT;
                    tx_sh_n    = req_wdata[7:0];
                end
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = CNT_BIT;
                    tx_bit_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end
            end
            TX_DATA: begin
                uart_tx = tx_sh[0];
                if (tx_cnt == '0) begin
                    tx_cnt_n = CNT_BIT;
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    tx_bit_n = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                end else begin
                    tx_cnt_n = tx_cnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) tx_state_n = TX_IDLE;
                else              tx_cnt_n   = tx_cnt - 1'b1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX ----------------
    logic          rx_s1, rx_s2;
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_data;
    logic          rx_valid, overrun, rx_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_sh    <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_sh    <= rx_sh_n;
            rx_bit   <= rx_bit_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_sh_n    = rx_sh;
        rx_bit_n   = rx_bit;
        rx_done    = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = CNT_HALF;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    // a line back at 1 by mid-start is a glitch, not a frame
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                    rx_cnt_n   = CNT_BIT;
                    rx_bit_n   = '0;
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_n = CNT_BIT;
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = RX_IDLE;
                    rx_done    = rx_s2;
                end else begin
                    rx_cnt_n = rx_cnt - 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // A completing byte outranks a same-cycle clear of either flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rx_done) rx_data <= rx_sh;
            if (rx_done)    rx_valid <= 1'b1;
            else if (rd_rx) rx_valid <= 1'b0;
            if (rx_done && rx_valid && !rd_rx) overrun <= 1'b1;
            else if (rd_ctrl)                  overrun <= 1'b0;
        end
    end

    // ---------------- read response ----------------
    uart_ctrl_t  ctrl;
    logic [31:0] rd_mux;

    assign ctrl = '{overrun: overrun, rx_valid: rx_valid, tx_ready: tx_ready};

    always_comb begin
        rd_mux = '0;
        unique case (addr_sel)
            ADDR_CTRL: rd_mux = {29'b0, ctrl};
            ADDR_RX:   rd_mux = {24'b0, rx_data};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd;
            if (rd) rsp_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: directed steps plus randomized RX traffic
// checked against a frame-level model of the register flags.
module tb_uart_mmio;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        uart_rx, uart_tx;

    int total = 0;
    int bad   = 0;

    // model of the register-visible RX/overrun state
    logic       m_valid = 1'b0;
    logic       m_ov    = 1'b0;
    logic [7:0] m_data  = 8'h00;

    uart_mmio #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_vld"}, rsp_valid, 1);
        chk(tag, rsp_data, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    // Count, per bit slot, how many of its 10 cycles carry the expected level.
    task automatic check_line(input logic [7:0] b);
        logic [9:0] f;
        int         hits;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            hits = 0;
            for (int c = 0; c < 10; c++) begin
                if (uart_tx === f[k]) hits++;
                @(negedge clk);
            end
            chk($sformatf("tx_%02h_bit%0d", b, k), hits, 10);
        end
    endtask

    task automatic idle_line(input int n, input string tag);
        int hits = 0;
        for (int c = 0; c < n; c++) begin
            if (uart_tx === 1'b1) hits++;
            @(negedge clk);
        end
        chk(tag, hits, n);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            repeat (10) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic m_frame(input logic [7:0] b, input logic stop);
        send_rx(b, stop);
        repeat (20) @(negedge clk);
        if (stop) begin
            if (m_valid) m_ov = 1'b1;
            m_valid = 1'b1;
            m_data  = b;
        end
    endtask

    task automatic m_rd_ctrl(input string tag);
        rd(4'h0, {29'b0, m_ov, m_valid, 1'b1}, tag);
        m_ov = 1'b0;
    endtask

    task automatic m_rd_rx(input string tag);
        rd(4'h4, {24'b0, m_data}, tag);
        m_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b0; uart_rx = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // reset held while the RX line toggles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            uart_rx = ~uart_rx;
        end
        uart_rx = 1'b1;
        chk("rst_tx", uart_tx, 1);
        chk("rst_rsp_vld", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("req_ready", req_ready, 1);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        m_rd_ctrl("ctrl_after_rst");
        @(negedge clk);
        chk("rsp_vld_one_cycle", rsp_valid, 0);
        m_rd_rx("rx_after_rst");
        rd(4'hC, 0, "unmapped_rd");
        rd(4'h8, 0, "tx_rd_zero");
        wr(4'h0, 32'hFFFF_FFFF);
        wr(4'hC, 32'h0000_00AA);
        m_rd_ctrl("ctrl_wr_ignored");
        idle_line(5, "tx_idle_after_bad_wr");

        // TX frame with busy status mid-frame
        wr(4'h8, 32'hABCD_EFA5);
        fork
            check_line(8'hA5);
            begin
                repeat (30) @(negedge clk);
                rd(4'h0, 0, "ctrl_tx_busy");
            end
        join
        m_rd_ctrl("ctrl_tx_done");

        // write while busy is dropped
        wr(4'h8, 32'h11);
        fork
            check_line(8'h11);
            begin
                repeat (4) @(negedge clk);
                wr(4'h8, 32'h22);
            end
        join
        idle_line(20, "tx_drop_no_frame");
        m_rd_ctrl("ctrl_after_drop");

        // back-to-back random TX frames
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            wr(4'h8, {24'h0, b});
            check_line(b);
        end

        // RX basic
        m_frame(8'h3C, 1'b1);
        m_rd_ctrl("ctrl_rx_valid");
        m_rd_rx("rx_3c");
        m_rd_ctrl("ctrl_rx_cleared");

        // overrun, then back-to-back reads
        m_frame(8'h01, 1'b1);
        m_frame(8'h02, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h0;
        @(negedge clk);
        req_addr = 4'h4;
        chk("b2b_ctrl_vld", rsp_valid, 1);
        chk("b2b_ctrl_ovr", rsp_data, {29'b0, m_ov, m_valid, 1'b1});
        m_ov = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_rx_vld", rsp_valid, 1);
        chk("b2b_rx_02", rsp_data, {24'b0, m_data});
        m_valid = 1'b0;
        m_rd_ctrl("ctrl_after_ovr");

        // framing error
        m_frame(8'($urandom), 1'b0);
        m_rd_ctrl("ctrl_framing");

        // glitch on RX, then confirm the receiver still works
        @(negedge clk); uart_rx = 1'b0;
        repeat (3) @(negedge clk); uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        m_rd_ctrl("ctrl_glitch");
        m_frame(8'h5A, 1'b1);
        m_rd_rx("rx_after_glitch");

        // randomized RX traffic against the model
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0:       m_frame(8'($urandom), 1'b1);
                1:       m_frame(8'($urandom), 1'($urandom_range(0, 1)));
                2:       m_rd_ctrl($sformatf("rand_ctrl_%0d", i));
                default: m_rd_rx($sformatf("rand_rx_%0d", i));
            endcase
        end

        // reset mid-TX at data bit 3 (line bit 4)
        m_frame(8'hC3, 1'b1);
        wr(4'h8, 32'h00);
        repeat (45) @(negedge clk);
        chk("tx_pre_rst", uart_tx, 0);
        #2 rst = 1'b0;
        #1 chk("tx_rst_async", uart_tx, 1);
        chk("rsp_vld_rst_async", rsp_valid, 0);
        m_valid = 1'b0; m_ov = 1'b0; m_data = 8'h00;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        idle_line(10, "tx_idle_after_rst");
        m_rd_ctrl("ctrl_after_mid_rst");
        m_rd_rx("rx_after_mid_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
